// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Purpose : Shared definitions for the parametrised UART receiver.
//           - Parity mode codes used by the PARITY_MODE parameter.
//           - Receiver FSM state encoding.
//           - Counter width helper used to size the baud and bit counters.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package uart_pkg;

    // Parity mode codes for PARITY_MODE
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Receiver FSM states, walked in this order for every frame
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rxState_t;

    // Bits needed for a counter that must hold values 0..maxVal
    function automatic int cntWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Purpose : Synchronous receive FIFO used by uart_rx_param when the
//           UART_RX_FIFO_EN macro is defined. Head word is presented
//           combinationally on rd_data; a read and a write may happen in the
//           same cycle, including when full (the read frees the slot first).
// Ports   : clk      - system clock, rising edge
//           rst      - asynchronous active-high reset
//           wr_en    - write wr_data this cycle
//           wr_data  - word to store
//           rd_en    - pop the head word this cycle (ignored when empty)
//           rd_data  - head word
//           full     - level == DEPTH
//           empty    - level == 0
//           level    - words held, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             w_doWr;
    logic             w_doRd;

    // A pop is only real when something is held; a push into a full FIFO is
    // allowed when a pop in the same cycle frees the slot.
    assign w_doRd = rd_en && !empty;
    assign w_doWr = wr_en && (!full || w_doRd);

    // Storage, pointers and occupancy. DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doWr) begin
                r_mem[r_wrPtr] <= wr_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_doRd) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doWr, w_doRd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign rd_data = r_mem[r_rdPtr];
    assign full    = (r_level == LVL_W'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;

endmodule

// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
// Purpose : Parametrised UART receiver (DATA_BITS data bits LSB first,
//           optional even/odd parity, 1 or 2 stop bits) with a valid/ready
//           output handshake and framing, parity and overrun error pulses.
// Config  : define UART_RX_FIFO_EN to buffer words in a FIFO_DEPTH-entry
//           uart_rx_fifo; otherwise a single holding register is used and
//           FIFO_DEPTH only sizes rx_level.
// Ports   : clk        - system clock, rising edge
//           rst        - asynchronous active-high reset
//           rx         - serial line, idle high, asynchronous to clk
//           rx_data    - head-of-buffer word, valid while rx_valid=1
//           rx_valid   - word available
//           rx_ready   - consumer accepts when rx_valid && rx_ready
//           rx_busy    - FSM is not idle
//           frame_err  - 1-cycle pulse, a stop bit was sampled low
//           parity_err - 1-cycle pulse, parity mismatch
//           overrun    - 1-cycle pulse, good word dropped because buffer full
//           rx_level   - words held
// -----------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              rx,
    output logic [DATA_BITS-1:0]              rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    output logic                              rx_busy,
    output logic                              frame_err,
    output logic                              parity_err,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level
);

    localparam int BAUD_W   = cntWidth(CLKS_PER_BIT);
    localparam int BIT_W    = cntWidth(DATA_BITS);
    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int LVL_W    = $clog2(FIFO_DEPTH + 1);

    logic                 r_rxMeta;
    logic                 r_rxSync;
    logic                 r_rxSyncD;
    rxState_t             r_state;
    logic [BAUD_W-1:0]    r_baudCnt;
    logic [BIT_W-1:0]     r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parityBit;
    logic                 r_stopBad;
    logic                 r_frameErr;
    logic                 r_parityErr;
    logic                 r_overrun;

    logic w_halfTick;
    logic w_bitTick;
    logic w_lastStop;
    logic w_stopBadNow;
    logic w_parityExp;
    logic w_parityBad;
    logic w_accept;
    logic w_full;
    logic w_wrEn;

    // Two-flop synchroniser plus one extra stage for falling-edge detection.
    // Everything loads 1 so reset never looks like a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rxMeta  <= 1'b1;
            r_rxSync  <= 1'b1;
            r_rxSyncD <= 1'b1;
        end else begin
            r_rxMeta  <= rx;
            r_rxSync  <= r_rxMeta;
            r_rxSyncD <= r_rxSync;
        end
    end

    // Start is checked half a bit after the edge, every later sample one full
    // bit after the previous one, which lands each sample mid-bit.
    assign w_halfTick = (r_baudCnt == BAUD_W'(HALF_BIT - 1));
    assign w_bitTick  = (r_baudCnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_lastStop = (r_state == ST_STOP) && w_bitTick &&
                        (r_bitCnt == BIT_W'(STOP_BITS - 1));

    // Frame verdict, valid on the last stop sample cycle. Earlier stop bits
    // are folded into r_stopBad, the last one is the live sample.
    assign w_stopBadNow = r_stopBad | ~r_rxSync;
    assign w_parityExp  = (^r_shift) ^ (PARITY_MODE == PARITY_ODD);
    assign w_parityBad  = (PARITY_MODE != PARITY_NONE) && (r_parityBit != w_parityExp);

    // A consumer accept in the same cycle frees the slot, so the buffer only
    // counts as full when nothing is leaving.
    assign w_accept = rx_valid && rx_ready;
    assign w_wrEn   = w_lastStop && !w_stopBadNow && !w_parityBad && !w_full;

    // Receiver FSM: counters, shift register and the registered error pulses.
    // Returns to idle on the last stop sample so a following start bit with
    // no idle gap is still seen as a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_baudCnt   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_parityBit <= 1'b0;
            r_stopBad   <= 1'b0;
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frameErr  <= 1'b0;
            r_parityErr <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rxSyncD && !r_rxSync) begin
                        r_state   <= ST_START;
                        r_baudCnt <= '0;
                        r_bitCnt  <= '0;
                        r_stopBad <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_halfTick) begin
                        r_baudCnt <= '0;
                        r_state   <= r_rxSync ? ST_IDLE : ST_DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bitTick) begin
                        r_baudCnt <= '0;
                        r_shift   <= {r_rxSync, r_shift[DATA_BITS-1:1]};
                        if (r_bitCnt == BIT_W'(DATA_BITS - 1)) begin
                            r_bitCnt <= '0;
                            r_state  <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_bitTick) begin
                        r_baudCnt   <= '0;
                        r_parityBit <= r_rxSync;
                        r_state     <= ST_STOP;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bitTick) begin
                        r_baudCnt <= '0;
                        if (w_lastStop) begin
                            r_state     <= ST_IDLE;
                            r_frameErr  <= w_stopBadNow;
                            r_parityErr <= !w_stopBadNow && w_parityBad;
                            r_overrun   <= !w_stopBadNow && !w_parityBad && w_full;
                        end else begin
                            r_stopBad <= w_stopBadNow;
                            r_bitCnt  <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rx_busy    = (r_state != ST_IDLE);
    assign frame_err  = r_frameErr;
    assign parity_err = r_parityErr;
    assign overrun    = r_overrun;

`ifdef UART_RX_FIFO_EN
    logic w_fifoFull;
    logic w_fifoEmpty;

    assign w_full   = w_fifoFull && !w_accept;
    assign rx_valid = !w_fifoEmpty;

    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wrEn),
        .wr_data (r_shift),
        .rd_en   (w_accept),
        .rd_data (rx_data),
        .full    (w_fifoFull),
        .empty   (w_fifoEmpty),
        .level   (rx_level)
    );
`else
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_holdValid;

    assign w_full = r_holdValid && !w_accept;

    // Single holding register: a new word replaces an accepted one in the
    // same cycle, otherwise an accept empties it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_holdValid <= 1'b0;
        end else if (w_wrEn) begin
            r_hold      <= r_shift;
            r_holdValid <= 1'b1;
        end else if (w_accept) begin
            r_holdValid <= 1'b0;
        end
    end

    assign rx_data  = r_hold;
    assign rx_valid = r_holdValid;
    assign rx_level = LVL_W'(r_holdValid);
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
// Purpose : Self-checking bench for uart_rx_param. One 8N1 receiver plus an
//           even-parity and an odd-parity receiver sharing a second line.
//           Honours UART_RX_FIFO_EN for the buffer capacity.
// -----------------------------------------------------------------------------
`timescale 1ns/10ps
module tb_uart_rx_param;

    localparam int BIT_NS     = 100;
    localparam int FIFO_DEPTH = 4;
    localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
`ifdef UART_RX_FIFO_EN
    localparam int CAP = FIFO_DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    logic rxMain, rxPar, readyMain, readyPar;

    logic [7:0]       dataMain, dataEven, dataOdd;
    logic             validMain, validEven, validOdd;
    logic             busyMain, busyEven, busyOdd;
    logic             ferrMain, ferrEven, ferrOdd;
    logic             perrMain, perrEven, perrOdd;
    logic             ovrMain, ovrEven, ovrOdd;
    logic [LVL_W-1:0] levelMain, levelEven, levelOdd;

    logic [7:0] accMain[$];
    logic [7:0] accEven[$];
    logic [7:0] accOdd[$];
    int ferrCntMain, perrCntMain, ovrCntMain, perrCntEven, perrCntOdd;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic [7:0] data;
        logic       stopBit;
        int         gapBits;
        int         expAccepts;
        logic [7:0] expWord;
        int         expFrameErr;
    } mainVec_t;

    typedef struct {
        logic [7:0] data;
        logic       parityBit;
        int         expEvenAcc;
        int         expOddAcc;
    } parVec_t;

    mainVec_t   mainVecs [8];
    parVec_t    parVecs [5];
    logic [7:0] ovrData [5];

    always #1 clk = ~clk;

    uart_rx_param #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(0),
                    .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)) dutMain (
        .clk(clk), .rst(rst), .rx(rxMain), .rx_data(dataMain), .rx_valid(validMain),
        .rx_ready(readyMain), .rx_busy(busyMain), .frame_err(ferrMain),
        .parity_err(perrMain), .overrun(ovrMain), .rx_level(levelMain));

    uart_rx_param #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(1),
                    .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)) dutEven (
        .clk(clk), .rst(rst), .rx(rxPar), .rx_data(dataEven), .rx_valid(validEven),
        .rx_ready(readyPar), .rx_busy(busyEven), .frame_err(ferrEven),
        .parity_err(perrEven), .overrun(ovrEven), .rx_level(levelEven));

    uart_rx_param #(.CLKS_PER_BIT(50), .DATA_BITS(8), .PARITY_MODE(2),
                    .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)) dutOdd (
        .clk(clk), .rst(rst), .rx(rxPar), .rx_data(dataOdd), .rx_valid(validOdd),
        .rx_ready(readyPar), .rx_busy(busyOdd), .frame_err(ferrOdd),
        .parity_err(perrOdd), .overrun(ovrOdd), .rx_level(levelOdd));

    // Observe accepted words and error pulses on the falling edge, where the
    // handshake seen here is the one the next rising edge performs.
    always @(negedge clk) begin
        if (validMain && readyMain) accMain.push_back(dataMain);
        if (validEven && readyPar)  accEven.push_back(dataEven);
        if (validOdd && readyPar)   accOdd.push_back(dataOdd);
        if (ferrMain) ferrCntMain++;
        if (perrMain) perrCntMain++;
        if (ovrMain)  ovrCntMain++;
        if (perrEven) perrCntEven++;
        if (perrOdd)  perrCntOdd++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearObs();
        accMain.delete();
        accEven.delete();
        accOdd.delete();
        ferrCntMain = 0;
        perrCntMain = 0;
        ovrCntMain  = 0;
        perrCntEven = 0;
        perrCntOdd  = 0;
    endtask

    task automatic setLine(input int line, input logic v);
        if (line == 0) rxMain = v;
        else           rxPar  = v;
    endtask

    task automatic driveBit(input int line, input logic v);
        setLine(line, v);
        #(BIT_NS);
    endtask

    // Start, 8 data bits LSB first, optional parity, one stop bit; the line
    // is left idle-high afterwards.
    task automatic sendFrame(input int line, input logic [7:0] data,
                             input logic withParity, input logic parityBit,
                             input logic stopBit);
        driveBit(line, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(line, data[i]);
        if (withParity) driveBit(line, parityBit);
        driveBit(line, stopBit);
        setLine(line, 1'b1);
    endtask

    task automatic setReady(input int line, input logic v);
        @(posedge clk);
        #0.2;
        if (line == 0) readyMain = v;
        else           readyPar  = v;
    endtask

    task automatic applyStimulus(input mainVec_t v);
        clearObs();
        sendFrame(0, v.data, 1'b0, 1'b0, v.stopBit);
        #(v.gapBits * BIT_NS);
    endtask

    initial begin
        // 0x34/0x38/0x32 back to back, then a bad stop bit and recovery.
        mainVecs[0] = '{8'h34, 1'b1, 0, 1, 8'h34, 0};
        mainVecs[1] = '{8'h38, 1'b1, 0, 1, 8'h38, 0};
        mainVecs[2] = '{8'h32, 1'b1, 2, 1, 8'h32, 0};
        mainVecs[3] = '{8'h55, 1'b0, 2, 0, 8'h00, 1};
        mainVecs[4] = '{8'hA5, 1'b1, 1, 1, 8'hA5, 0};
        mainVecs[5] = '{8'h00, 1'b1, 0, 1, 8'h00, 0};
        mainVecs[6] = '{8'hFF, 1'b1, 0, 1, 8'hFF, 0};
        mainVecs[7] = '{8'h80, 1'b1, 1, 1, 8'h80, 0};

        // 0x34 has three ones, so its even parity bit is 1 and odd is 0.
        parVecs[0] = '{8'h34, 1'b1, 1, 0};
        parVecs[1] = '{8'h34, 1'b0, 0, 1};
        parVecs[2] = '{8'h00, 1'b0, 1, 0};
        parVecs[3] = '{8'h01, 1'b1, 1, 0};
        parVecs[4] = '{8'hFF, 1'b1, 0, 1};

        ovrData = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        rst       = 1'b1;
        rxMain    = 1'b1;
        rxPar     = 1'b1;
        readyMain = 1'b1;
        readyPar  = 1'b1;
        clearObs();
        #10;
        checkOutput("reset_valid", validMain, 0);
        checkOutput("reset_data", dataMain, 0);
        checkOutput("reset_level", levelMain, 0);
        checkOutput("reset_busy", busyMain, 0);
        checkOutput("reset_errs", {ferrMain, perrMain, ovrMain}, 0);
        rst = 1'b0;
        #200;

        // Table-driven 8N1 frames
        foreach (mainVecs[i]) begin
            applyStimulus(mainVecs[i]);
            checkOutput($sformatf("vec%0d_accepts", i), accMain.size(), mainVecs[i].expAccepts);
            if (accMain.size() > 0)
                checkOutput($sformatf("vec%0d_word", i), accMain[0], mainVecs[i].expWord);
            checkOutput($sformatf("vec%0d_frame_err", i), ferrCntMain, mainVecs[i].expFrameErr);
            checkOutput($sformatf("vec%0d_other_errs", i), perrCntMain + ovrCntMain, 0);
        end

        // Parity frames to the even and odd receivers
        foreach (parVecs[i]) begin
            clearObs();
            sendFrame(1, parVecs[i].data, 1'b1, parVecs[i].parityBit, 1'b1);
            #(BIT_NS);
            checkOutput($sformatf("par%0d_even_acc", i), accEven.size(), parVecs[i].expEvenAcc);
            checkOutput($sformatf("par%0d_even_perr", i), perrCntEven, 1 - parVecs[i].expEvenAcc);
            checkOutput($sformatf("par%0d_odd_acc", i), accOdd.size(), parVecs[i].expOddAcc);
            checkOutput($sformatf("par%0d_odd_perr", i), perrCntOdd, 1 - parVecs[i].expOddAcc);
            if (accEven.size() > 0) checkOutput($sformatf("par%0d_even_word", i), accEven[0], parVecs[i].data);
            if (accOdd.size() > 0)  checkOutput($sformatf("par%0d_odd_word", i), accOdd[0], parVecs[i].data);
        end

        // 50 ns glitch on an idle line is a false start
        clearObs();
        rxMain = 1'b0;
        #40;
        checkOutput("glitch_busy_high", busyMain, 1);
        #10;
        rxMain = 1'b1;
        #(BIT_NS);
        checkOutput("glitch_busy_low", busyMain, 0);
        checkOutput("glitch_no_word", accMain.size() + validMain, 0);
        checkOutput("glitch_no_flags", ferrCntMain + perrCntMain + ovrCntMain, 0);

        // Overrun: buffer saturates, only the last frame is dropped
        setReady(0, 1'b0);
        clearObs();
        for (int k = 0; k <= CAP; k++) begin
            sendFrame(0, ovrData[k], 1'b0, 1'b0, 1'b1);
            checkOutput($sformatf("ovr%0d_level", k), levelMain, (k + 1 > CAP) ? CAP : k + 1);
            checkOutput($sformatf("ovr%0d_pulses", k), ovrCntMain, (k == CAP) ? 1 : 0);
            checkOutput($sformatf("ovr%0d_valid", k), validMain, 1);
        end
        setReady(0, 1'b1);
        #(BIT_NS);
        checkOutput("drain_count", accMain.size(), CAP);
        for (int k = 0; k < CAP; k++) begin
            if (k < accMain.size())
                checkOutput($sformatf("drain%0d_word", k), accMain[k], ovrData[k]);
        end
        checkOutput("drain_level", levelMain, 0);

        // Reset during data bit 3 with a word already held
        setReady(0, 1'b0);
        clearObs();
        sendFrame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
        checkOutput("held_valid", validMain, 1);
        checkOutput("held_data", dataMain, 8'h5A);
        driveBit(0, 1'b0);
        for (int i = 0; i < 3; i++) driveBit(0, 1'b0);
        setLine(0, 1'b1);
        #50;
        checkOutput("midframe_busy", busyMain, 1);
        rst = 1'b1;
        #0.5;
        checkOutput("rst_mid_valid", validMain, 0);
        checkOutput("rst_mid_data", dataMain, 0);
        checkOutput("rst_mid_level", levelMain, 0);
        checkOutput("rst_mid_busy", busyMain, 0);
        #9.5;
        rxMain = 1'b1;
        #10;
        rst = 1'b0;
        #200;
        setReady(0, 1'b1);
        clearObs();
        sendFrame(0, 8'h38, 1'b0, 1'b0, 1'b1);
        #(BIT_NS);
        checkOutput("post_rst_accepts", accMain.size(), 1);
        if (accMain.size() > 0) checkOutput("post_rst_word", accMain[0], 8'h38);
        checkOutput("post_rst_flags", ferrCntMain + perrCntMain + ovrCntMain, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
